// File: rtl/voice_mixer_if.sv
// voice_mixer_if: beat input bus from the oscillator stage and the tagged
// voice-sample output bus toward the voice VCA / output mixer.
interface voice_mixer_if #(
  parameter int VOICES    = 8,
  parameter int V_WIDTH   = 3,
  parameter int O_WIDTH   = 3,
  parameter int OUT_WIDTH = 20
);
  logic                        in_valid;
  logic [O_WIDTH-1:0]          in_ox;
  logic [V_WIDTH-1:0]          in_vx;
  logic signed [16:0]          sine_lut_out;
  logic [7:0]                  osc_level;
  logic [VOICES-1:0]           voice_free;
  logic                        voice_valid;
  logic signed [OUT_WIDTH-1:0] voice_out;
  logic [V_WIDTH-1:0]          voice_vx;
  logic                        sat_flag;
  logic                        seq_err;

  modport master (
    output in_valid, in_ox, in_vx, sine_lut_out, osc_level, voice_free,
    input  voice_valid, voice_out, voice_vx, sat_flag, seq_err
  );

  modport slave (
    input  in_valid, in_ox, in_vx, sine_lut_out, osc_level, voice_free,
    output voice_valid, voice_out, voice_vx, sat_flag, seq_err
  );
endinterface

// File: rtl/voice_mixer.sv
// voice_mixer: scales each oscillator sample by its level and sums the V_OSC
// oscillators of a voice into one saturated, tagged voice sample per frame.
// Pipeline: p1 = product register, p2 = frame FSM + accumulator, then the
// output register (voice_valid 3 cycles after the last beat).
// Optional build macro VOICE_MIXER_MUTE_FREE_EN: completed frames whose voice
// is flagged in voice_free are emitted as silent (0, no sat_flag).
module voice_mixer #(
  parameter int VOICES    = 8,
  parameter int V_OSC     = 8,
  parameter int V_WIDTH   = 3,
  parameter int O_WIDTH   = 3,
  parameter int OUT_SHIFT = 4,
  parameter int OUT_WIDTH = 20
) (
  input  logic            sCLK_XVXENVS,
  input  logic            reset,
  voice_mixer_if.slave    bus
);

  localparam int DATA_W = 17;
  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = 29;

  localparam logic [O_WIDTH-1:0] LAST_OX = O_WIDTH'(V_OSC - 1);
  localparam logic [O_WIDTH-1:0] ONE_OX  = O_WIDTH'(1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    ACC_W'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic logic signed [OUT_WIDTH-1:0] sat_val(
    input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      sat_val = SAT_MAX[OUT_WIDTH-1:0];
    else if (v < SAT_MIN) sat_val = SAT_MIN[OUT_WIDTH-1:0];
    else                  sat_val = v[OUT_WIDTH-1:0];
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
    sat_hit = (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  // ---------------------------------------------------------------- p1
  logic                     vld_p1_q;
  logic [O_WIDTH-1:0]       ox_p1_q;
  logic [V_WIDTH-1:0]       vx_p1_q;
  logic signed [PROD_W-1:0] prod_p1_d, prod_p1_q;
  logic signed [PROD_W-1:0] smp_ext, lvl_ext;

  // Signed sample times zero-extended (always positive) level.
  always_comb begin
    smp_ext   = {{(PROD_W-DATA_W){bus.sine_lut_out[DATA_W-1]}}, bus.sine_lut_out};
    lvl_ext   = {{(PROD_W-COEF_W){1'b0}}, bus.osc_level};
    prod_p1_d = smp_ext * lvl_ext;
  end

  // Product register; beat tags travel with it.
  always_ff @(posedge sCLK_XVXENVS) begin
    if (reset) vld_p1_q <= 1'b0;
    else       vld_p1_q <= bus.in_valid;
    if (bus.in_valid) begin
      prod_p1_q <= prod_p1_d;
      ox_p1_q   <= bus.in_ox;
      vx_p1_q   <= bus.in_vx;
    end
  end

  // ---------------------------------------------------------------- p2
  state_t                  state_d, state_q;
  logic [O_WIDTH-1:0]      exp_ox_d, exp_ox_q;
  logic [V_WIDTH-1:0]      vx_lat_d, vx_lat_q;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic                    seq_err_d, seq_err_q;
  logic                    last_p2_d, last_p2_q;
  logic [V_WIDTH-1:0]      vx_p2_d, vx_p2_q;
  logic signed [ACC_W-1:0] prod_acc;
  logic                    start;

  // Frame sequencing: load on ox==0, accumulate in-order beats, drop on error.
  always_comb begin
    state_d   = state_q;
    exp_ox_d  = exp_ox_q;
    vx_lat_d  = vx_lat_q;
    acc_d     = acc_q;
    seq_err_d = seq_err_q;
    last_p2_d = 1'b0;
    vx_p2_d   = vx_p2_q;
    start     = 1'b0;
    prod_acc  = {{(ACC_W-PROD_W){prod_p1_q[PROD_W-1]}}, prod_p1_q};
    if (vld_p1_q) begin
      case (state_q)
        IDLE: begin
          if (ox_p1_q == '0) start = 1'b1;
          else               seq_err_d = 1'b1;
        end
        ACCUM: begin
          if (ox_p1_q == exp_ox_q && vx_p1_q == vx_lat_q) begin
            acc_d = acc_q + prod_acc;
            if (ox_p1_q == LAST_OX) begin
              last_p2_d = 1'b1;
              vx_p2_d   = vx_p1_q;
              state_d   = IDLE;
            end else begin
              exp_ox_d = exp_ox_q + ONE_OX;
            end
          end else if (ox_p1_q == '0) begin
            seq_err_d = 1'b1;
            start     = 1'b1;
          end else begin
            seq_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (start) begin
        acc_d    = prod_acc;
        vx_lat_d = vx_p1_q;
        exp_ox_d = ONE_OX;
        if (ox_p1_q == LAST_OX) begin
          last_p2_d = 1'b1;
          vx_p2_d   = vx_p1_q;
          state_d   = IDLE;
        end else begin
          state_d = ACCUM;
        end
      end
    end
  end

  // FSM, accumulator and sticky error register.
  always_ff @(posedge sCLK_XVXENVS) begin
    if (reset) begin
      state_q   <= IDLE;
      exp_ox_q  <= '0;
      vx_lat_q  <= '0;
      acc_q     <= '0;
      seq_err_q <= 1'b0;
      last_p2_q <= 1'b0;
      vx_p2_q   <= '0;
    end else begin
      state_q   <= state_d;
      exp_ox_q  <= exp_ox_d;
      vx_lat_q  <= vx_lat_d;
      acc_q     <= acc_d;
      seq_err_q <= seq_err_d;
      last_p2_q <= last_p2_d;
      vx_p2_q   <= vx_p2_d;
    end
  end

  // ------------------------------------------------------------ output
  logic signed [ACC_W-1:0]     acc_shift;
  logic                        voice_valid_d, voice_valid_q;
  logic signed [OUT_WIDTH-1:0] voice_out_d, voice_out_q;
  logic [V_WIDTH-1:0]          voice_vx_d, voice_vx_q;
  logic                        sat_flag_d, sat_flag_q;

`ifndef VOICE_MIXER_MUTE_FREE_EN
  logic unused_free;
  assign unused_free = ^bus.voice_free;
`endif

  // Scale, saturate and tag the finished frame; sample holds between frames.
  always_comb begin
    acc_shift     = acc_q >>> OUT_SHIFT;
    voice_valid_d = last_p2_q;
    voice_out_d   = voice_out_q;
    voice_vx_d    = voice_vx_q;
    sat_flag_d    = 1'b0;
    if (last_p2_q) begin
      voice_out_d = sat_val(acc_shift);
      voice_vx_d  = vx_p2_q;
      sat_flag_d  = sat_hit(acc_shift);
`ifdef VOICE_MIXER_MUTE_FREE_EN
      if (bus.voice_free[vx_p2_q]) begin
        voice_out_d = '0;
        sat_flag_d  = 1'b0;
      end
`endif
    end
  end

  // Output register.
  always_ff @(posedge sCLK_XVXENVS) begin
    if (reset) begin
      voice_valid_q <= 1'b0;
      voice_out_q   <= '0;
      voice_vx_q    <= '0;
      sat_flag_q    <= 1'b0;
    end else begin
      voice_valid_q <= voice_valid_d;
      voice_out_q   <= voice_out_d;
      voice_vx_q    <= voice_vx_d;
      sat_flag_q    <= sat_flag_d;
    end
  end

  assign bus.voice_valid = voice_valid_q;
  assign bus.voice_out   = voice_out_q;
  assign bus.voice_vx    = voice_vx_q;
  assign bus.sat_flag    = sat_flag_q;
  assign bus.seq_err     = seq_err_q;

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed and random beat streams against a frame-level
// reference model (list of products per frame, summed when complete).
module tb_voice_mixer;
  localparam int VOICES    = 8;
  localparam int V_OSC     = 8;
  localparam int V_WIDTH   = 3;
  localparam int O_WIDTH   = 3;
  localparam int OUT_SHIFT = 4;
  localparam int OUT_WIDTH = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  voice_mixer_if #(.VOICES(VOICES), .V_WIDTH(V_WIDTH), .O_WIDTH(O_WIDTH),
                   .OUT_WIDTH(OUT_WIDTH)) bus ();

  voice_mixer #(.VOICES(VOICES), .V_OSC(V_OSC), .V_WIDTH(V_WIDTH),
                .O_WIDTH(O_WIDTH), .OUT_SHIFT(OUT_SHIFT),
                .OUT_WIDTH(OUT_WIDTH)) dut (
    .sCLK_XVXENVS(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int     cyc;
    int     vx;
    longint out;
    int     sat;
  } rec_t;

  rec_t   exp_q[$];
  rec_t   obs_q[$];
  longint fr_prods[$];
  int     fr_vx = 0;
  int     m_seq_err = 0;
  int     checks = 0;
  int     errors = 0;

  // Capture every emitted voice sample with the cycle it appeared on.
  always @(negedge clk) begin
    if (bus.voice_valid === 1'b1) begin
      rec_t r;
      r.cyc = cyc;
      r.vx  = int'(bus.voice_vx);
      r.out = longint'(bus.voice_out);
      r.sat = int'(bus.sat_flag);
      obs_q.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void emit(input int c, input int vx, input longint sum);
    rec_t   r;
    longint sh;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
    lo = -(longint'(1) <<< (OUT_WIDTH - 1));
    sh = sum >>> OUT_SHIFT;
    r.cyc = c;
    r.vx  = vx;
    r.sat = 0;
    if (sh > hi) begin
      r.out = hi; r.sat = 1;
    end else if (sh < lo) begin
      r.out = lo; r.sat = 1;
    end else begin
      r.out = sh;
    end
`ifdef VOICE_MIXER_MUTE_FREE_EN
    if (bus.voice_free[vx] === 1'b1) begin
      r.out = 0; r.sat = 0;
    end
`endif
    exp_q.push_back(r);
  endfunction

  // A frame is the ordered list of products seen so far for one voice.
  function automatic void model_beat(input int c, input int vx, input int ox,
                                     input int s, input int lvl);
    longint p;
    longint sum;
    p = longint'(s) * longint'(lvl);
    if (fr_prods.size() == 0) begin
      if (ox == 0) begin
        fr_vx = vx; fr_prods.push_back(p);
      end else begin
        m_seq_err = 1;
      end
    end else if (ox == fr_prods.size() && vx == fr_vx) begin
      fr_prods.push_back(p);
    end else begin
      m_seq_err = 1;
      fr_prods.delete();
      if (ox == 0) begin
        fr_vx = vx; fr_prods.push_back(p);
      end
    end
    if (fr_prods.size() == V_OSC) begin
      sum = 0;
      foreach (fr_prods[i]) sum += fr_prods[i];
      emit(c + 3, fr_vx, sum);
      fr_prods.delete();
    end
  endfunction

  task automatic beat(input int vx, input int ox, input int s, input int lvl);
    bus.in_valid     = 1'b1;
    bus.in_vx        = vx[V_WIDTH-1:0];
    bus.in_ox        = ox[O_WIDTH-1:0];
    bus.sine_lut_out = s[16:0];
    bus.osc_level    = lvl[7:0];
    model_beat(cyc, vx, ox, s, lvl);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input int vx, input int s, input int lvl);
    for (int ox = 0; ox < V_OSC; ox++) beat(vx, ox, s, lvl);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", bus.voice_valid, 0);
    chk("rst_out", bus.voice_out, 0);
    chk("rst_vx", bus.voice_vx, 0);
    chk("rst_sat", bus.sat_flag, 0);
    chk("rst_seq_err", bus.seq_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    fr_prods.delete();
    m_seq_err = 0;
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_cyc%0d", tag, i), obs_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s_vx%0d", tag, i), obs_q[i].vx, exp_q[i].vx);
      chk($sformatf("%s_out%0d", tag, i), obs_q[i].out, exp_q[i].out);
      chk($sformatf("%s_sat%0d", tag, i), obs_q[i].sat, exp_q[i].sat);
    end
    chk({tag, "_seq_err"}, bus.seq_err, m_seq_err);
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic longint first_out();
    return (obs_q.size() > 0) ? obs_q[0].out : -64'sd999999999;
  endfunction

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_ox        = '0;
    bus.in_vx        = '0;
    bus.sine_lut_out = '0;
    bus.osc_level    = '0;
    bus.voice_free   = '0;
    do_reset();

    // Basic sum.
    frame(2, 1000, 128);
    idle(6);
    chk("basic_const", first_out(), 64000);
    compare("basic");

    // Positive and negative clipping.
    frame(0, 65535, 255);
    idle(6);
    chk("satpos_const", first_out(), 524287);
    compare("satpos");
    frame(7, -65536, 255);
    idle(6);
    chk("satneg_const", first_out(), -524288);
    compare("satneg");

    // Skipped oscillator, then a clean frame.
    beat(1, 0, 256, 1); beat(1, 1, 256, 1); beat(1, 2, 256, 1); beat(1, 5, 256, 1);
    idle(4);
    frame(1, 256, 1);
    idle(6);
    chk("seqerr_const", first_out(), 128);
    chk("seqerr_sticky", bus.seq_err, 1);
    compare("seqerr");

    // Back-to-back frames.
    frame(3, 16, 2);
    frame(4, 16, 2);
    idle(6);
    chk("b2b_spacing", (obs_q.size() == 2) ? obs_q[1].cyc - obs_q[0].cyc : -1, 8);
    compare("b2b");

    // Reset in the middle of a frame.
    for (int ox = 0; ox <= 4; ox++) beat(5, ox, 700, 200);
    do_reset();
    frame(5, -1600, 1);
    idle(6);
    chk("midrst_const", first_out(), -800);
    compare("midrst");

    // Free-voice muting (ignored unless the mute build option is on).
    bus.voice_free = 8'b0000_0100;
    frame(2, 3000, 50);
    idle(2);
    frame(1, 3000, 50);
    idle(6);
    compare("mute");
    bus.voice_free = '0;

    // Random streams with gaps and occasional sequence corruption.
    for (int f = 0; f < 40; f++) begin
      int vx;
      vx = int'($urandom_range(0, VOICES - 1));
      for (int ox = 0; ox < V_OSC; ox++) begin
        int s, lvl, bo, bv;
        s   = int'($urandom_range(0, 131071)) - 65536;
        lvl = int'($urandom_range(0, 255));
        bo  = ox;
        bv  = vx;
        if ($urandom_range(0, 29) == 0) bo = int'($urandom_range(0, V_OSC - 1));
        if ($urandom_range(0, 39) == 0) bv = int'($urandom_range(0, VOICES - 1));
        beat(bv, bo, s, lvl);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
    end
    idle(6);
    compare("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
